ddr_mem_arbiter: RTL
====================

// Module: ddr_mem_arbiter
// PURPOSE
//  Shares the single DDR2 memory-controller user port between two requesters:
//  port 0 = UART program/data loader, port 1 = core load/store unit.
//  One transaction outstanding at a time, round-robin grant, per-port done pulse.
//  Sits inside io_core_controller between requesters and the DDR2 controller wrapper.
// PARAMETERS
//  ADDR_W      27    word address width of memory port
//  DATA_W      32    data width
//  TIMEOUT_CYC 1023  max cycles waiting for read data before aborting with error
// PORTS
//  clk           in   1       system clock; single clock domain
//  rst           in   1       synchronous, active-high reset
//  req0/req1     in   1       request; held high with fields stable until doneN
//  we0/we1       in   1       1 = write, 0 = read
//  addr0/addr1   in   ADDR_W  word address
//  wdata0/wdata1 in   DATA_W  write data
//  done0/done1   out  1       one-cycle pulse: transaction complete
//  rdata0/rdata1 out  DATA_W  read data; valid with doneN, held until next doneN
//  err0/err1     out  1       with doneN: read timed out (rdataN = 0)
//  mem_req       out  1       command valid to DDR controller
//  mem_we        out  1       command is write
//  mem_addr      out  ADDR_W  command address
//  mem_wdata     out  DATA_W  write data (with command)
//  mem_ready     in   1       controller accepts command when mem_req & mem_ready
//  mem_rvalid    in   1       read data valid (one cycle)
//  mem_rdata     in   DATA_W  read data
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; last-grant pointer = 1 (port 0 wins first tie).
//  FSM IDLE -> ISSUE -> (WAIT) -> DONE -> IDLE:
//   IDLE : if any req: grant sole requester, or on tie the port != last grant;
//          latch we/addr/wdata of granted port; -> ISSUE. No req: stay.
//   ISSUE: mem_req=1 with latched fields; hold until mem_ready.
//          Accepted write -> DONE. Accepted read -> WAIT, clear timeout counter.
//   WAIT : mem_rvalid -> latch mem_rdata, -> DONE.
//          Counter reaches TIMEOUT_CYC without rvalid -> err, rdata=0, -> DONE.
//   DONE : doneG=1 (errG with it), rdataG updated on reads only; last-grant = G;
//          -> IDLE.
//  Latency: req at cycle t -> mem_req at t+1. Write with mem_ready at t+1 ->
//   done at t+2. Read with rvalid at cycle r -> done at r+1.
//  Requester may deassert req or present a new request the cycle after done.
//   Re-arbitration then takes at least one IDLE cycle, so back-to-back requests
//   from both ports alternate.
//  Requests arriving during ISSUE/WAIT/DONE wait; never dropped, never merged.
//  Ungranted port's done/rdata/err do not change.
//  mem_rvalid outside WAIT is ignored. In WAIT, rvalid on the timeout cycle wins.
//  mem_req/mem_we/mem_addr/mem_wdata are registered; they change only on entry
//   to ISSUE and stay stable while mem_req & !mem_ready.
//  mem_req is 0 in IDLE/WAIT/DONE.
//  Reset mid-transaction -> IDLE immediately, no done pulse. The DDR controller
//   is reset by the same rst.
//  Timeout counter: $clog2(TIMEOUT_CYC+1) bits, saturating, cleared on WAIT entry.
// STRUCTURE
//  Package mem_arb_pkg: state enum {IDLE, ISSUE, WAIT, DONE}; PORT_LOADER=0,
//   PORT_CORE=1.
//  Sub-module rr_arb2: 2-way round-robin grant from {req, last_grant};
//   combinational, one-hot output.
// TESTING
//  1 Single write on port 0, mem_ready=1 -> mem_req@t+1 with addr/wdata;
//    done0@t+2; done1 stays 0.
//  2 Read on port 1, addr=0x100; rvalid 5 cycles after accept with 0xDEADBEEF
//    -> done1 one cycle later, rdata1=0xDEADBEEF, err1=0.
//  3 req0 & req1 held continuously, writes -> grants alternate 0,1,0,1.
//    No port waits more than one other transaction.
//  4 mem_ready low 10 cycles in ISSUE -> mem_* fields stable throughout;
//    single accept; exactly one done.
//  5 Read, no rvalid -> done+err after TIMEOUT_CYC; rdata=0.
//    A stray rvalid in IDLE afterwards is ignored.
//  6 rst asserted in WAIT -> next cycle all outputs 0, IDLE.
//    New request afterwards completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and port indices for the DDR2 user-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    localparam logic PORT_LOADER = 1'b0;
    localparam logic PORT_CORE   = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the port that was not granted last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt    = '0;
        gnt[0] = req[0] & (~req[1] | (last_grant == PORT_CORE));
        gnt[1] = req[1] & (~req[0] | (last_grant == PORT_LOADER));
    end

endmodule

// File: rtl/ddr_mem_arbiter.sv
// Shares the DDR2 controller user port between the UART loader (port 0) and
// the core load/store unit (port 1); one transaction in flight, round-robin.
module ddr_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [1:0]       gnt;
    logic             any_gnt;
    logic             last_grant;
    logic             cur_port;
    logic             err_flag;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;

    rr_arb2 u_rr_arb2 (
        .req        ({req1, req0}),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign any_gnt = |gnt;
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_gnt) state_nxt = ISSUE;
            ISSUE:   if (mem_ready) state_nxt = mem_we ? DONE : WAIT;
            WAIT:    if (mem_rvalid || tmo_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done0 = (state == DONE) && (cur_port == PORT_LOADER);
        done1 = (state == DONE) && (cur_port == PORT_CORE);
        err0  = done0 && err_flag;
        err1  = done1 && err_flag;
    end

    // Command fields are captured once on IDLE->ISSUE and left untouched until
    // the next grant, so they stay stable through any mem_ready stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= PORT_CORE;
            cur_port   <= PORT_LOADER;
            err_flag   <= 1'b0;
            tmo_cnt    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_gnt) begin
                        cur_port  <= gnt[1] ? PORT_CORE : PORT_LOADER;
                        mem_req   <= 1'b1;
                        mem_we    <= gnt[1] ? we1 : we0;
                        mem_addr  <= gnt[1] ? addr1 : addr0;
                        mem_wdata <= gnt[1] ? wdata1 : wdata0;
                    end
                end
                ISSUE: begin
                    if (mem_ready) begin
                        mem_req  <= 1'b0;
                        tmo_cnt  <= '0;
                        err_flag <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (cur_port == PORT_CORE) rdata1 <= mem_rdata;
                        else                       rdata0 <= mem_rdata;
                    end else if (tmo_hit) begin
                        err_flag <= 1'b1;
                        if (cur_port == PORT_CORE) rdata1 <= '0;
                        else                       rdata0 <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DONE: begin
                    last_grant <= cur_port;
                end
                default: ;
            endcase
        end
    end

endmodule
